qspi_sram_responder: RTL and testbench



---
 rtl/qspi_sram_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_sram_responder.sv
// ----------------------------------------------------------------------------
// qspi_sram_responder
//   Target-side model of a 23LC1024-style quad (SQI) serial SRAM. It supports
//   sequential READ (0x03) and WRITE (0x02) into an internal byte array. sck,
//   cs_n and sio_i are oversampled on clk, and no logic is clocked by sck.
//
// Parameters
//   ADDR_WIDTH    implemented byte-address bits; array depth = 2**ADDR_WIDTH
//   DUMMY_CYCLES  sck cycles between the last address nibble and the first
//                 read nibble (2 = one dummy byte in quad mode)
//
// Ports
//   clk      system clock, at least 8x the sck frequency
//   reset_n  asynchronous active-low reset
//   cs_n     chip select from the initiator (async to clk)
//   sck      serial clock from the initiator (async to clk)
//   sio_i    SIO[3:0] from the pads; bit 3 is the nibble MSB
//   sio_o    SIO[3:0] driven during the read data phase
//   sio_oe   1 = responder drives SIO
//   busy     1 while the synchronized cs_n is low
//
// Build option
//   QSPI_SRAM_PAGE_WRAP_EN  when defined, sequential access wraps inside a
//                           32-byte page (needs ADDR_WIDTH >= 5). Otherwise
//                           it wraps across the whole array.
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for cs_n low (only once cs_n has been seen high)
//   S_CMD    | shifting in the two command nibbles
//   S_ADDR   | shifting in six address nibbles, MSB first
//   S_DUMMY  | skipping the dummy sck cycles before read data
//   S_RDATA  | driving array data on sck falls, high nibble first
//   S_WDATA  | collecting nibble pairs and writing bytes on sck rises
//   S_IGNORE | unsupported command; inert until cs_n deasserts
// ----------------------------------------------------------------------------
module qspi_sram_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       sck,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  logic                  r_cs_s1, r_cs_s2;
  logic                  r_vld_s1, r_vld_s2;
  logic                  r_armed;
  logic                  r_sck_s1, r_sck_s2, r_sck_d;
  logic [3:0]            r_sio_s1, r_sio_s2;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_phase;
  logic [3:0]            r_hi;
  logic                  r_is_read;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_sio_o;
  logic                  r_sio_oe;
  logic                  r_busy;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_rise, w_fall;
  logic                  w_mem_we;
  logic [7:0]            w_mem_wdata;
  logic [7:0]            w_rd_byte;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  // cs_n flops reset high so the bus looks idle right after reset. The valid
  // pipeline marks when r_cs_s2 holds a real sample of the pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_vld_s1 <= 1'b0;
      r_vld_s2 <= 1'b0;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_sio_s1 <= 4'h0;
      r_sio_s2 <= 4'h0;
    end else begin
      r_cs_s1  <= cs_n;
      r_cs_s2  <= r_cs_s1;
      r_vld_s1 <= 1'b1;
      r_vld_s2 <= r_vld_s1;
      r_sck_s1 <= sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_sio_s1 <= sio_i;
      r_sio_s2 <= r_sio_s1;
    end
  end

  assign w_rise = r_sck_s2 & ~r_sck_d;
  assign w_fall = ~r_sck_s2 & r_sck_d;

`ifdef QSPI_SRAM_PAGE_WRAP_EN
  assign w_addr_next = {r_addr[ADDR_WIDTH-1:5], r_addr[4:0] + 5'd1};
`else
  assign w_addr_next = r_addr + ADDR_WIDTH'(1);
`endif

  assign w_rd_byte   = r_mem[r_addr];
  assign w_mem_wdata = {r_hi, r_sio_s2};
  // A deasserted cs_n blocks the write, so a half byte is never committed.
  assign w_mem_we    = (r_state == S_WDATA) && w_rise && r_phase && !r_cs_s2;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_hi      <= 4'h0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_sio_o   <= 4'h0;
      r_sio_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_busy <= ~r_cs_s2;
      // A transaction already running when reset is released is not joined.
      if (r_vld_s2 && r_cs_s2) r_armed <= 1'b1;

      if (r_cs_s2) begin
        // cs_n high wins over any sck edge seen in the same cycle.
        r_state  <= S_IDLE;
        r_sio_oe <= 1'b0;
        r_sio_o  <= 4'h0;
        r_phase  <= 1'b0;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_armed) begin
              r_state <= S_CMD;
              r_cnt   <= '0;
              r_phase <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              if (r_cnt == '0) begin
                r_hi  <= r_sio_s2;
                r_cnt <= CNT_W'(1);
              end else begin
                r_cnt <= '0;
                case ({r_hi, r_sio_s2})
                  8'h03: begin r_is_read <= 1'b1; r_state <= S_ADDR; end
                  8'h02: begin r_is_read <= 1'b0; r_state <= S_ADDR; end
                  default: r_state <= S_IGNORE;
                endcase
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              // Six nibbles shift through, so only the low address bits remain.
              r_addr <= ADDR_WIDTH'({r_addr, r_sio_s2});
              if (r_cnt == CNT_W'(5)) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_state <= r_is_read ? S_DUMMY : S_WDATA;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          S_DUMMY: begin
            if (w_rise) begin
              if (r_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_state <= S_RDATA;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              r_sio_oe <= 1'b1;
              if (!r_phase) begin
                r_sio_o <= w_rd_byte[7:4];
                r_phase <= 1'b1;
              end else begin
                r_sio_o <= w_rd_byte[3:0];
                r_addr  <= w_addr_next;
                r_phase <= 1'b0;
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              if (!r_phase) begin
                r_hi    <= r_sio_s2;
                r_phase <= 1'b1;
              end else begin
                r_addr  <= w_addr_next;
                r_phase <= 1'b0;
              end
            end
          end
          S_IGNORE: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sio_o  = r_sio_o;
  assign sio_oe = r_sio_oe;
  assign busy   = r_busy;

endmodule

// File: tb/tb_qspi_sram_responder.sv
module tb_qspi_sram_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int DUMMY = 2;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n;
  logic       sck;
  logic [3:0] sio_drv;
  logic [3:0] sio_o;
  logic       sio_oe;
  logic       busy;

  qspi_sram_responder #(.ADDR_WIDTH(AW), .DUMMY_CYCLES(DUMMY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs_n    (cs_n),
    .sck     (sck),
    .sio_i   (sio_drv),
    .sio_o   (sio_o),
    .sio_oe  (sio_oe),
    .busy    (busy)
  );

  initial forever #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] rd_q [$];
  bit         oe_bad;

  typedef struct {
    string       name;
    bit          wr;
    logic [23:0] addr;
    int          len;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int next_a(input int a);
`ifdef QSPI_SRAM_PAGE_WRAP_EN
    return (a & (DEPTH - 32)) | ((a + 1) % 32);
`else
    return (a + 1) % DEPTH;
`endif
  endfunction

  task automatic nib(input logic [3:0] d, output logic [3:0] s, output logic oe);
    sio_drv = d;
    #HALF;
    s  = sio_o;
    oe = sio_oe;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic nib_noe(input logic [3:0] d);
    logic [3:0] s;
    logic       oe;
    nib(d, s, oe);
    if (oe !== 1'b0) oe_bad = 1'b1;
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    cs_n = 1'b0;
    #100;
    nib_noe(cmd[7:4]);
    nib_noe(cmd[3:0]);
    for (int i = 5; i >= 0; i--) nib_noe(a[i*4 +: 4]);
  endtask

  task automatic cs_end();
    #HALF;
    cs_n    = 1'b1;
    sio_drv = 4'h0;
    #200;
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] h, l;
    logic       o1, o2;
    rd_q.delete();
    oe_bad = 1'b0;
    hdr(8'h03, a);
    for (int i = 0; i < DUMMY; i++) nib_noe(4'hF);
    for (int i = 0; i < n; i++) begin
      nib(4'h0, h, o1);
      nib(4'h0, l, o2);
      if (o1 !== 1'b1 || o2 !== 1'b1) oe_bad = 1'b1;
      rd_q.push_back({h, l});
    end
    cs_end();
    check("rd_oe_released", {31'd0, sio_oe}, 32'd0);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] wq [$]);
    int p;
    oe_bad = 1'b0;
    hdr(8'h02, a);
    foreach (wq[i]) begin
      nib_noe(wq[i][7:4]);
      nib_noe(wq[i][3:0]);
    end
    cs_end();
    p = int'(a) % DEPTH;
    foreach (wq[i]) begin
      model[p] = wq[i];
      p = next_a(p);
    end
  endtask

  initial begin
    logic [7:0] wq [$];
    logic [3:0] h;
    logic       o;
    int         mism;

    vecs[0] = '{"wr_010",      1'b1, 24'h000010, 2, 8'hA5, 8'h3C};
    vecs[1] = '{"rd_010",      1'b0, 24'h000010, 2, 8'hA5, 8'h3C};
    vecs[2] = '{"wr_3ff",      1'b1, 24'h0003FF, 2, 8'h11, 8'h22};
`ifdef QSPI_SRAM_PAGE_WRAP_EN
    vecs[3] = '{"rd_wrap_lo",  1'b0, 24'h0003E0, 1, 8'h22, 8'h00};
`else
    vecs[3] = '{"rd_wrap_lo",  1'b0, 24'h000000, 1, 8'h22, 8'h00};
`endif
    vecs[4] = '{"rd_3ff",      1'b0, 24'h0003FF, 1, 8'h11, 8'h00};
    vecs[5] = '{"wr_03f",      1'b1, 24'h00003F, 2, 8'h77, 8'h88};
`ifdef QSPI_SRAM_PAGE_WRAP_EN
    vecs[6] = '{"rd_after_3f", 1'b0, 24'h000020, 1, 8'h88, 8'h00};
`else
    vecs[6] = '{"rd_after_3f", 1'b0, 24'h000040, 1, 8'h88, 8'h00};
`endif
    vecs[7] = '{"rd_hi_addr",  1'b0, 24'hABC010, 2, 8'hA5, 8'h3C};

    reset_n = 1'b0;
    cs_n    = 1'b1;
    sck     = 1'b0;
    sio_drv = 4'h0;
    #2;
    check("reset_oe",   {31'd0, sio_oe}, 32'd0);
    check("reset_sio",  {28'd0, sio_o},  32'd0);
    check("reset_busy", {31'd0, busy},   32'd0);
    #50;
    reset_n = 1'b1;
    #100;
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Fill the array with random bytes so every location has a known value.
    for (int pg = 0; pg < DEPTH / 32; pg++) begin
      wq.delete();
      for (int j = 0; j < 32; j++) wq.push_back(8'($urandom));
      do_write(24'(pg * 32), wq);
    end

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        wq.delete();
        wq.push_back(vecs[i].b0);
        if (vecs[i].len > 1) wq.push_back(vecs[i].b1);
        do_write(vecs[i].addr, wq);
        check({vecs[i].name, "_oe"}, {31'd0, oe_bad}, 32'd0);
      end else begin
        do_read(vecs[i].addr, vecs[i].len);
        check({vecs[i].name, "_b0"}, {24'd0, rd_q[0]}, {24'd0, vecs[i].b0});
        if (vecs[i].len > 1)
          check({vecs[i].name, "_b1"}, {24'd0, rd_q[1]}, {24'd0, vecs[i].b1});
        check({vecs[i].name, "_oe"}, {31'd0, oe_bad}, 32'd0);
      end
    end

    // Abort mid-byte: only the complete byte 0xBE lands.
    oe_bad = 1'b0;
    hdr(8'h02, 24'h000020);
    nib_noe(4'hB);
    nib_noe(4'hE);
    nib_noe(4'hF);
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    #HALF;
    cs_n = 1'b1;
    #30;
    check("abort_oe_off",   {31'd0, sio_oe}, 32'd0);
    check("abort_busy_off", {31'd0, busy},   32'd0);
    #210;
    model[32'h020] = 8'hBE;
    do_read(24'h000020, 2);
    check("abort_020", {24'd0, rd_q[0]}, 32'h0000_00BE);
    check("abort_021", {24'd0, rd_q[1]}, {24'd0, model[32'h021]});

    // Unknown command: inert for the whole transaction.
    oe_bad = 1'b0;
    cs_n = 1'b0;
    #100;
    nib_noe(4'h0);
    nib_noe(4'h5);
    for (int i = 0; i < 8; i++) nib_noe(4'hF);
    cs_end();
    check("unknown_cmd_oe", {31'd0, oe_bad}, 32'd0);

    // Reset during read data, then ensure the open transaction is not joined.
    oe_bad = 1'b0;
    hdr(8'h03, 24'h000010);
    for (int i = 0; i < DUMMY; i++) nib_noe(4'hF);
    nib(4'h0, h, o);
    check("rst_pre_nib", {27'd0, o, h}, {27'd0, 1'b1, 4'hA});
    #20;
    reset_n = 1'b0;
    #1;
    check("rst_async_oe",  {31'd0, sio_oe}, 32'd0);
    check("rst_async_sio", {28'd0, sio_o},  32'd0);
    #29;
    reset_n = 1'b1;
    oe_bad = 1'b0;
    for (int i = 0; i < 6; i++) nib_noe(4'h0);
    check("rst_no_join", {31'd0, oe_bad}, 32'd0);
    cs_end();
    do_read(24'h000010, 1);
    check("rst_reread_010", {24'd0, rd_q[0]}, 32'h0000_00A5);

    // Randomized transactions against the array model.
    for (int t = 0; t < 24; t++) begin
      int          kind;
      int          len;
      int          p;
      logic [23:0] a;
      logic [7:0]  cmd;
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 6));
      a    = 24'($urandom);
      if (kind < 4) begin
        wq.delete();
        for (int j = 0; j < len; j++) wq.push_back(8'($urandom));
        do_write(a, wq);
      end else if (kind < 8) begin
        do_read(a, len);
        p = int'(a) % DEPTH;
        for (int j = 0; j < len; j++) begin
          check($sformatf("rand_rd_t%0d_b%0d", t, j), {24'd0, rd_q[j]}, {24'd0, model[p]});
          p = next_a(p);
        end
        check($sformatf("rand_rd_t%0d_oe", t), {31'd0, oe_bad}, 32'd0);
      end else begin
        cmd = 8'($urandom);
        if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'h9F;
        oe_bad = 1'b0;
        cs_n = 1'b0;
        #100;
        nib_noe(cmd[7:4]);
        nib_noe(cmd[3:0]);
        for (int j = 0; j < len * 2; j++) nib_noe(4'($urandom));
        cs_end();
        check($sformatf("rand_junk_t%0d_oe", t), {31'd0, oe_bad}, 32'd0);
      end
    end

    // Whole-array readback against the model.
    mism = 0;
    for (int pg = 0; pg < DEPTH / 32; pg++) begin
      do_read(24'(pg * 32), 32);
      for (int j = 0; j < 32; j++)
        if (rd_q[j] !== model[pg * 32 + j]) mism++;
    end
    check("full_array_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
